dispatch_queue_mw: RTL and testbench

Multi-wide circular dispatch queue between decode/rename and issue. Accepts up to ENQ_W decoded instructions per cycle and presents the oldest DEQ_W entries to issue in program order. Issue pops up to DEQ_W entries per cycle. A synchronous flush discards all entries on branch mispredict or exception. Generalises the single-lane dispatch FIFO with multi-lane ports, an occupancy count and flush.

---
 rtl/dispatch_queue_mw_if.sv | 24 ++
 rtl/dispatch_queue_mw.sv | 153 +++++++++++++++
 tb/tb_dispatch_queue_mw.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_mw_if.sv
// Enqueue/dequeue bus for the multi-wide dispatch queue.
// master: decode/rename + issue side; slave: the queue itself.
interface dispatch_queue_mw_if #(
  parameter int unsigned ENTRY_W = 65,
  parameter int unsigned ENQ_W   = 2,
  parameter int unsigned DEQ_W   = 2
);
  logic [ENQ_W-1:0]         in_valid;
  logic [ENQ_W*ENTRY_W-1:0] in_data;
  logic                     in_ready;
  logic [DEQ_W-1:0]         out_valid;
  logic [DEQ_W*ENTRY_W-1:0] out_data;
  logic [DEQ_W-1:0]         deq_en;

  modport master (
    output in_valid, in_data, deq_en,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, deq_en,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dispatch_queue_mw.sv
// Multi-wide circular dispatch queue between decode/rename and issue.
// Up to ENQ_W entries enter per cycle (all-or-nothing), the oldest DEQ_W
// entries are presented combinationally in program order, and issue pops up
// to DEQ_W per cycle. flush empties the queue synchronously.
// Optional macro DISPATCH_QUEUE_PERF_EN adds saturating stall/empty counters.
module dispatch_queue_mw #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 65,
  parameter int unsigned ENQ_W   = 2,
  parameter int unsigned DEQ_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  dispatch_queue_mw_if.slave      bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
`ifdef DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_empty_cycles
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  // Pointers carry a wrap bit above the index; count is kept explicitly.
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]    enq_lead, deq_lead;
  logic [PtrW-1:0]    n_enq, n_deq;
  logic               enq_fire;
  logic [IdxW-1:0]    wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];

  // Leading-ones counts of the lane masks; lanes after the first zero are ignored.
  always_comb begin : lead_ones
    logic enq_run;
    logic deq_run;
    enq_lead = '0;
    deq_lead = '0;
    enq_run  = 1'b1;
    deq_run  = 1'b1;
    for (int unsigned i = 0; i < ENQ_W; i++) begin
      if (enq_run && bus.in_valid[i]) begin
        enq_lead = enq_lead + PtrW'(1);
      end else begin
        enq_run = 1'b0;
      end
    end
    for (int unsigned i = 0; i < DEQ_W; i++) begin
      if (deq_run && bus.deq_en[i]) begin
        deq_lead = deq_lead + PtrW'(1);
      end else begin
        deq_run = 1'b0;
      end
    end
  end

  // Readiness looks only at registered occupancy, never at same-cycle pops.
  assign bus.in_ready = (PtrW'(DEPTH) - count_q) >= PtrW'(ENQ_W);

  // Flush wins over both enqueue and dequeue.
  assign enq_fire = bus.in_ready && !flush;

  // Accepted enqueue and clamped dequeue amounts for this cycle.
  always_comb begin
    n_enq = enq_fire ? enq_lead : '0;
    n_deq = '0;
    if (!flush) begin
      n_deq = (deq_lead > count_q) ? count_q : deq_lead;
    end
  end

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + n_enq;
    rd_ptr_d = rd_ptr_q + n_deq;
    count_d  = count_q + n_enq - n_deq;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write; intentionally not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_W; i++) begin
      if (enq_fire && (PtrW'(i) < enq_lead)) begin
        mem_q[wr_idx + IdxW'(i)] <= bus.in_data[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  // Zero-latency read of the oldest DEQ_W entries; newly written data shows next cycle.
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int unsigned i = 0; i < DEQ_W; i++) begin
      bus.out_valid[i]                      = count_q > PtrW'(i);
      bus.out_data[i*ENTRY_W +: ENTRY_W]    = mem_q[rd_idx + IdxW'(i)];
    end
  end

  assign count = count_q;
  assign full  = (count_q == PtrW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] empty_cyc_q;

  // Saturating performance counters; only rst_n clears them, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      empty_cyc_q <= '0;
    end else begin
      if ((|bus.in_valid) && !bus.in_ready && (stall_cyc_q != 32'hFFFF_FFFF)) begin
        stall_cyc_q <= stall_cyc_q + 32'd1;
      end
      if (empty && (empty_cyc_q != 32'hFFFF_FFFF)) begin
        empty_cyc_q <= empty_cyc_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cyc_q;
  assign perf_empty_cycles = empty_cyc_q;
`endif

endmodule

// File: tb/tb_dispatch_queue_mw.sv
// Self-checking bench for dispatch_queue_mw (DEPTH=8, ENQ_W=2, DEQ_W=2).
// Reference model: a plain queue of entries plus push/pop totals.
module tb_dispatch_queue_mw;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ENTRY_W = 65;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
  logic       full;
  logic       empty;
`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_empty_cycles;
`endif

  dispatch_queue_mw_if #(.ENTRY_W(ENTRY_W), .ENQ_W(2), .DEQ_W(2)) bus ();

  dispatch_queue_mw #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .ENQ_W   (2),
    .DEQ_W   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ENTRY_W-1:0] model_q[$];
  int pushes = 0;
  int pops   = 0;
  int total_enq = 0;
  longint exp_stall = 0;
  longint exp_empty = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lead(input logic [1:0] m);
    if (!m[0]) return 0;
    return m[1] ? 2 : 1;
  endfunction

  function automatic logic [ENTRY_W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[ENTRY_W-1:0];
  endfunction

  function automatic logic [1:0] rnd_mask();
    logic [1:0] m;
    m = 2'(int'($urandom_range(0, 3)));
    return m;
  endfunction

  task automatic check_state();
    int sz;
    sz = model_q.size();
    chk("count", 128'(count), 128'(sz));
    chk("full", 128'(full), 128'(sz == DEPTH));
    chk("empty", 128'(empty), 128'(sz == 0));
    chk("in_ready", 128'(bus.in_ready), 128'((DEPTH - sz) >= 2));
    chk("out_valid", 128'(bus.out_valid), 128'({sz > 1, sz > 0}));
    chk("rd_ptr", 128'(dut.rd_ptr_q), 128'(pops % 16));
    chk("wr_ptr", 128'(dut.wr_ptr_q), 128'(pushes % 16));
    if (sz > 0) chk("lane0_data", 128'(bus.out_data[ENTRY_W-1:0]), 128'(model_q[0]));
    if (sz > 1) chk("lane1_data", 128'(bus.out_data[2*ENTRY_W-1:ENTRY_W]), 128'(model_q[1]));
`ifdef DISPATCH_QUEUE_PERF_EN
    chk("perf_stall", 128'(perf_stall_cycles), 128'(exp_stall));
    chk("perf_empty", 128'(perf_empty_cycles), 128'(exp_empty));
`endif
  endtask

  // One cycle: drive, check pre-edge state, clock, advance the model.
  task automatic step(input logic [1:0] iv, input logic [1:0] dq, input logic fl,
                      input logic [ENTRY_W-1:0] d0, input logic [ENTRY_W-1:0] d1);
    int  sz;
    int  ne;
    int  nd;
    bit  rdy;
    bus.in_valid = iv;
    bus.in_data  = {d1, d0};
    bus.deq_en   = dq;
    flush        = fl;
    #1;
    check_state();
    sz  = model_q.size();
    rdy = (DEPTH - sz) >= 2;
    if ((iv != 2'b00) && !rdy) exp_stall++;
    if (sz == 0) exp_empty++;
    @(posedge clk);
    #1;
    if (fl) begin
      model_q.delete();
      pushes = 0;
      pops   = 0;
    end else begin
      ne = rdy ? lead(iv) : 0;
      nd = (lead(dq) > sz) ? sz : lead(dq);
      for (int i = 0; i < nd; i++) void'(model_q.pop_front());
      if (ne > 0) model_q.push_back(d0);
      if (ne > 1) model_q.push_back(d1);
      pushes    += ne;
      pops      += nd;
      total_enq += ne;
    end
  endtask

  initial begin
    logic [ENTRY_W-1:0] x;
    logic [ENTRY_W-1:0] y;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.deq_en   = '0;
    flush        = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill with 2-wide enqueues; the fifth attempt is blocked at full.
    for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, rnd(), rnd());

    // Full: simultaneous 2-wide enqueue is refused while two entries pop.
    step(2'b11, 2'b11, 1'b0, rnd(), rnd());

    // Drain down to one entry, then a 2-wide pop clamps to one.
    step(2'b00, 2'b11, 1'b0, '0, '0);
    step(2'b00, 2'b11, 1'b0, '0, '0);
    step(2'b00, 2'b01, 1'b0, '0, '0);
    step(2'b00, 2'b11, 1'b0, '0, '0);
    step(2'b00, 2'b11, 1'b0, '0, '0);

    // Fill/drain phases past the pointer wrap with mixed lane widths.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) step(rnd_mask(), ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00,
                                        1'b0, rnd(), rnd());
      for (int i = 0; i < 10; i++) step(($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00, rnd_mask(),
                                        1'b0, rnd(), rnd());
    end
    chk("wrap_traffic", 128'(total_enq >= 24), 128'(1));

    // Fully random traffic including non-thermometer masks and flushes.
    for (int i = 0; i < 80; i++) step(rnd_mask(), rnd_mask(), ($urandom_range(0, 15) == 0),
                                      rnd(), rnd());

    // Build count=5, then flush against a live enqueue and dequeue.
    step(2'b00, 2'b00, 1'b1, '0, '0);
    step(2'b11, 2'b00, 1'b0, rnd(), rnd());
    step(2'b11, 2'b00, 1'b0, rnd(), rnd());
    step(2'b01, 2'b00, 1'b0, rnd(), rnd());
    step(2'b11, 2'b01, 1'b1, rnd(), rnd());
    x = rnd();
    y = rnd();
    step(2'b11, 2'b00, 1'b0, x, y);
    chk("flush_idx0", 128'(dut.mem_q[0]), 128'(x));
    chk("flush_idx1", 128'(dut.mem_q[1]), 128'(y));

    // count=3, then asynchronous reset between clock edges.
    step(2'b01, 2'b00, 1'b0, rnd(), rnd());
    step(2'b00, 2'b00, 1'b0, '0, '0);
    bus.in_valid = 2'b11;
    bus.deq_en   = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
`ifdef DISPATCH_QUEUE_PERF_EN
    chk("rst_perf_stall", 128'(perf_stall_cycles), 128'(0));
    chk("rst_perf_empty", 128'(perf_empty_cycles), 128'(0));
`endif
    model_q.delete();
    pushes    = 0;
    pops      = 0;
    exp_stall = 0;
    exp_empty = 0;
    #2 rst_n = 1'b1;

    // Post-reset sanity traffic.
    step(2'b11, 2'b00, 1'b0, rnd(), rnd());
    step(2'b01, 2'b11, 1'b0, rnd(), rnd());
    step(2'b00, 2'b11, 1'b0, '0, '0);
    step(2'b00, 2'b00, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
